// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants for the KEY/SW memory-mapped responder
package io_pkg;

  localparam int KEYBITS = 4;
  localparam int SWBITS  = 10;

  localparam logic [31:0] ADDRKDATA = 32'hFFFFF080;
  localparam logic [31:0] ADDRKCTRL = 32'hFFFFF084;
  localparam logic [31:0] ADDRSDATA = 32'hFFFFF090;
  localparam logic [31:0] ADDRSCTRL = 32'hFFFFF094;

  localparam int CTRL_READY = 0;
  localparam int CTRL_OVR   = 2;
  localparam int CTRL_IE    = 8;

endpackage

// File: rtl/io_keysw_responder_if.sv
// rtl/io_keysw_responder_if.sv - MEM-stage load/store bus between the pipeline and the I/O responder
interface io_keysw_responder_if #(parameter int DBITS = 32) ();

  logic [DBITS-1:0] addr;
  logic             rd_en;
  logic             wr_en;
  logic [DBITS-1:0] wdata;
  logic             hit;
  logic [DBITS-1:0] rdata;
  logic             irq;

  modport master (output addr, rd_en, wr_en, wdata, input hit, rdata, irq);
  modport slave  (input addr, rd_en, wr_en, wdata, output hit, rdata, irq);

endinterface

// File: rtl/debouncer.sv
// rtl/debouncer.sv - two-flop synchronizer plus hold-time debounce with a one-cycle change pulse
module debouncer #(
  parameter int WIDTH  = 4,
  parameter int CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             changed
);

  localparam int CW = $clog2(CYCLES);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    count;
  logic             differ;

  assign differ  = (sync2 != stable);
  // Asserted on the very edge that stable takes the new value, so status logic updates in step.
  assign changed = differ && (count == CW'(CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      count  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (changed) begin
        stable <= sync2;
        count  <= '0;
      end else if (differ) begin
        count <= count + 1'b1;
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/io_keysw_responder.sv
// rtl/io_keysw_responder.sv - KEY/SW data and control/status registers answering MEM-stage loads and stores
module io_keysw_responder
  import io_pkg::*;
#(
  parameter int DBITS           = 32,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [KEYBITS-1:0]   KEY,
  input  logic [SWBITS-1:0]    SW,
  io_keysw_responder_if.slave  bus
);

  logic [KEYBITS-1:0] kdata;
  logic [SWBITS-1:0]  sdata;
  logic               kchg;
  logic               schg;

  debouncer #(.WIDTH(KEYBITS), .CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk     (clk),
    .reset   (reset),
    .raw     (~KEY),
    .stable  (kdata),
    .changed (kchg)
  );

  debouncer #(.WIDTH(SWBITS), .CYCLES(DEBOUNCE_CYCLES)) u_sw (
    .clk     (clk),
    .reset   (reset),
    .raw     (SW),
    .stable  (sdata),
    .changed (schg)
  );

  logic hit_kd, hit_kc, hit_sd, hit_sc;
  logic k_rd_clr, k_ctrl_wr, s_rd_clr, s_ctrl_wr;

  assign hit_kd = (bus.addr == ADDRKDATA);
  assign hit_kc = (bus.addr == ADDRKCTRL);
  assign hit_sd = (bus.addr == ADDRSDATA);
  assign hit_sc = (bus.addr == ADDRSCTRL);
  assign bus.hit = hit_kd | hit_kc | hit_sd | hit_sc;

  assign k_rd_clr  = bus.rd_en & hit_kd;
  assign k_ctrl_wr = bus.wr_en & hit_kc;
  assign s_rd_clr  = bus.rd_en & hit_sd;
  assign s_ctrl_wr = bus.wr_en & hit_sc;

  logic kready, kovr, kie;
  logic sready, sovr, sie;

  // A debounced change outranks both the DATA-read clear of Ready and a CTRL write clearing Overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      kready <= 1'b0;
      kovr   <= 1'b0;
      kie    <= 1'b0;
      sready <= 1'b0;
      sovr   <= 1'b0;
      sie    <= 1'b0;
    end else begin
      if (kchg)          kready <= 1'b1;
      else if (k_rd_clr) kready <= 1'b0;
      if (kchg && kready && !k_rd_clr)               kovr <= 1'b1;
      else if (k_ctrl_wr && !bus.wdata[CTRL_OVR])    kovr <= 1'b0;
      if (k_ctrl_wr) kie <= bus.wdata[CTRL_IE];

      if (schg)          sready <= 1'b1;
      else if (s_rd_clr) sready <= 1'b0;
      if (schg && sready && !s_rd_clr)               sovr <= 1'b1;
      else if (s_ctrl_wr && !bus.wdata[CTRL_OVR])    sovr <= 1'b0;
      if (s_ctrl_wr) sie <= bus.wdata[CTRL_IE];
    end
  end

  function automatic logic [DBITS-1:0] ctrl_word(input logic rdy, input logic ovr, input logic ie);
    ctrl_word             = '0;
    ctrl_word[CTRL_READY] = rdy;
    ctrl_word[CTRL_OVR]   = ovr;
    ctrl_word[CTRL_IE]    = ie;
  endfunction

  logic [DBITS-1:0] rdata_c;

  always_comb begin
    rdata_c = '0;
    if (hit_kd)      rdata_c[KEYBITS-1:0] = kdata;
    else if (hit_kc) rdata_c = ctrl_word(kready, kovr, kie);
    else if (hit_sd) rdata_c[SWBITS-1:0] = sdata;
    else if (hit_sc) rdata_c = ctrl_word(sready, sovr, sie);
  end

  assign bus.rdata = rdata_c;
  assign bus.irq   = (kready & kie) | (sready & sie);

  logic unused_wdata;
  assign unused_wdata = ^{bus.wdata[DBITS-1:CTRL_IE+1], bus.wdata[CTRL_IE-1:CTRL_OVR+1],
                          bus.wdata[CTRL_OVR-1:0]};

endmodule

// File: tb/tb_io_keysw_responder.sv
// tb/tb_io_keysw_responder.sv - directed bench with a behavioural model checked every cycle
module tb_io_keysw_responder;
  import io_pkg::*;

  localparam int DB = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [KEYBITS-1:0] KEY = 4'hF;
  logic [SWBITS-1:0]  SW = '0;

  io_keysw_responder_if #(.DBITS(32)) bus ();

  io_keysw_responder #(.DBITS(32), .DEBOUNCE_CYCLES(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .KEY   (KEY),
    .SW    (SW),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 0 = KEY (pressed=1), index 1 = SW.
  logic [15:0] m_d1 [2];
  logic [15:0] m_d2 [2];
  logic [15:0] m_deb [2];
  int          m_run [2];
  logic        m_rdy [2];
  logic        m_ovr [2];
  logic        m_ie  [2];
  bit          model_valid = 0;

  function automatic logic [31:0] daddr(input int d);
    return (d == 0) ? ADDRKDATA : ADDRSDATA;
  endfunction

  function automatic logic [31:0] caddr(input int d);
    return (d == 0) ? ADDRKCTRL : ADDRSCTRL;
  endfunction

  always @(posedge clk) begin
    logic [15:0]        raw;
    logic [KEYBITS-1:0] kp;
    logic               chg, rdclr, cwr, old_rdy;
    for (int d = 0; d < 2; d++) begin
      raw = '0;
      kp  = ~KEY;
      if (d == 0) raw[KEYBITS-1:0] = kp;
      else        raw[SWBITS-1:0]  = SW;
      if (reset) begin
        m_d1[d] = '0; m_d2[d] = '0; m_deb[d] = '0; m_run[d] = 0;
        m_rdy[d] = 0; m_ovr[d] = 0; m_ie[d] = 0;
      end else begin
        chg = 0;
        if (m_d2[d] != m_deb[d]) begin
          m_run[d] = m_run[d] + 1;
          if (m_run[d] == DB) begin
            m_deb[d] = m_d2[d];
            m_run[d] = 0;
            chg = 1;
          end
        end else begin
          m_run[d] = 0;
        end
        rdclr   = bus.rd_en && (bus.addr == daddr(d));
        cwr     = bus.wr_en && (bus.addr == caddr(d));
        old_rdy = m_rdy[d];
        if (cwr) begin
          if (!bus.wdata[2]) m_ovr[d] = 0;
          m_ie[d] = bus.wdata[8];
        end
        if (rdclr) m_rdy[d] = 0;
        if (chg) begin
          if (old_rdy && !rdclr) m_ovr[d] = 1;
          m_rdy[d] = 1;
        end
        m_d2[d] = m_d1[d];
        m_d1[d] = raw;
      end
    end
    model_valid = 1;
  end

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    for (int d = 0; d < 2; d++) begin
      if (a == daddr(d)) r[15:0] = m_deb[d];
      if (a == caddr(d)) begin
        r[0] = m_rdy[d];
        r[2] = m_ovr[d];
        r[8] = m_ie[d];
      end
    end
    return r;
  endfunction

  function automatic logic m_hit(input logic [31:0] a);
    return (a == ADDRKDATA) || (a == ADDRKCTRL) || (a == ADDRSDATA) || (a == ADDRSCTRL);
  endfunction

  always @(negedge clk) begin
    #4;
    if (model_valid) begin
      check("model_hit", bus.hit, m_hit(bus.addr));
      check("model_rdata", bus.rdata, m_rdata(bus.addr));
      check("model_irq", bus.irq, (m_rdy[0] & m_ie[0]) | (m_rdy[1] & m_ie[1]));
    end
  end

  task automatic idle();
    bus.addr = 32'h100; bus.rd_en = 0; bus.wr_en = 0; bus.wdata = '0;
  endtask

  task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string name);
    bus.addr = a; bus.rd_en = 0; bus.wr_en = 0;
    #1;
    check(name, bus.rdata, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    cycles(3);
    #1;
    check("t1_hit_0x100", bus.hit, 0);
    check("t1_irq", bus.irq, 0);
    @(negedge clk); reset = 0;
    peek(ADDRKCTRL, 32'h0, "t1_kctrl");
    peek(ADDRSCTRL, 32'h0, "t1_sctrl");
    @(negedge clk);
    peek(ADDRKDATA, 32'h0, "t1_kdata");
    peek(ADDRSDATA, 32'h0, "t1_sdata");

    // Key0 press: visible exactly 2+DB edges later
    @(negedge clk); idle(); KEY = 4'hE;
    cycles(5);
    peek(ADDRKDATA, 32'h0, "t2_kdata_early");
    @(negedge clk);
    peek(ADDRKDATA, 32'h1, "t2_kdata");
    peek(ADDRKCTRL, 32'h1, "t2_kctrl");
    @(negedge clk);
    bus.addr = ADDRKDATA; bus.rd_en = 1; #1;
    check("t2_read_kdata", bus.rdata, 32'h1);
    @(negedge clk);
    peek(ADDRKCTRL, 32'h0, "t2_kctrl_cleared");

    // Switch changes, overrun, W0C, IE
    @(negedge clk); idle(); SW = 10'h3;
    cycles(6);
    peek(ADDRSCTRL, 32'h1, "t3_sctrl_ready");
    peek(ADDRSDATA, 32'h3, "t3_sdata3");
    @(negedge clk); idle(); SW = 10'h7;
    cycles(6);
    peek(ADDRSCTRL, 32'h5, "t3_sctrl_ovr");
    peek(ADDRSDATA, 32'h7, "t3_sdata7");
    @(negedge clk);
    bus.addr = ADDRSCTRL; bus.wr_en = 1; bus.wdata = 32'h0;
    @(negedge clk);
    peek(ADDRSCTRL, 32'h1, "t3_ovr_cleared");
    bus.wr_en = 1; bus.wdata = 32'h104;
    @(negedge clk);
    peek(ADDRSCTRL, 32'h101, "t3_ie_set");
    check("t3_irq", bus.irq, 1);
    @(negedge clk); idle(); SW = 10'hF;
    cycles(5);
    bus.addr = ADDRSCTRL; bus.wr_en = 1; bus.wdata = 32'h100;
    @(negedge clk);
    peek(ADDRSCTRL, 32'h105, "t3_hw_set_wins");
    bus.wr_en = 1; bus.wdata = 32'h0;
    @(negedge clk);
    peek(ADDRSCTRL, 32'h1, "t3_sctrl_cleared");
    check("t3_irq_off", bus.irq, 0);

    // Release, clear, then a 3-cycle glitch that must not register
    @(negedge clk); idle(); KEY = 4'hF;
    cycles(6);
    peek(ADDRKDATA, 32'h0, "t4_released");
    peek(ADDRKCTRL, 32'h1, "t4_ready");
    @(negedge clk);
    bus.addr = ADDRKDATA; bus.rd_en = 1;
    @(negedge clk); idle(); KEY = 4'hE;
    cycles(3);
    KEY = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      peek(ADDRKCTRL, 32'h0, "t4_glitch_kctrl");
      peek(ADDRKDATA, 32'h0, "t4_glitch_kdata");
    end

    // Change lands on the same edge as a KDATA read
    @(negedge clk); idle(); KEY = 4'hE;
    cycles(6);
    peek(ADDRKCTRL, 32'h1, "t5_ready_before");
    @(negedge clk); idle(); KEY = 4'hC;
    cycles(5);
    bus.addr = ADDRKDATA; bus.rd_en = 1; #1;
    check("t5_read_old", bus.rdata, 32'h1);
    @(negedge clk);
    peek(ADDRKCTRL, 32'h1, "t5_ready_no_ovr");
    peek(ADDRKDATA, 32'h3, "t5_kdata");

    // Reset at count 3/4 of a switch change
    @(negedge clk); idle(); SW = 10'h155;
    cycles(5);
    reset = 1;
    @(negedge clk); reset = 0;
    peek(ADDRSDATA, 32'h0, "t6_sdata_reset");
    peek(ADDRSCTRL, 32'h0, "t6_sctrl_reset");
    cycles(5);
    peek(ADDRSDATA, 32'h0, "t6_not_yet");
    @(negedge clk);
    peek(ADDRSDATA, 32'h155, "t6_sdata");
    peek(ADDRSCTRL, 32'h1, "t6_sctrl");

    @(negedge clk); idle();
    @(negedge clk);
    #6;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
